// File: rtl/nbit_demux_router_if.sv
// Bus bundle for nbit_demux_router: upstream word/handshake plus the M channel outputs.
// The master modport is the producer/consumer side; the slave modport is the router.
interface nbit_demux_router_if #(
  parameter int unsigned N     = 5,
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned SEL_W = $clog2(M);

  logic [N-1:0]     in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic             in_valid;
  logic             in_ready;
  logic [M*N-1:0]   out_data;
  logic [M-1:0]     out_valid;
  logic [M-1:0]     out_ready;
  logic             err;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err, drop_cnt
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err, drop_cnt
  );
endinterface

// File: rtl/nbit_demux_router.sv
// Registered 1-to-M demultiplexer with per-channel valid/ready, broadcast, and a
// saturating counter of words dropped for an out-of-range select.
module nbit_demux_router #(
  parameter int unsigned N     = 5,
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  nbit_demux_router_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(M);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [M-1:0]     full_q, full_d;
  logic [M*N-1:0]   data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     can_acc, sel_oh, load;
  logic             sel_ok, ready, accept;

  // One-hot decode; an out-of-range select decodes to all zeros.
  always_comb begin
    sel_oh = '0;
    for (int unsigned k = 0; k < M; k++) begin
      sel_oh[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign sel_ok  = |sel_oh;
  assign can_acc = ~full_q | bus.out_ready;

  always_comb begin
    ready = 1'b0;
    if (rst) begin
      ready = 1'b0;
    end else if (bus.in_bcast) begin
      ready = &can_acc;
    end else if (sel_ok) begin
      ready = |(can_acc & sel_oh);
    end else begin
      ready = 1'b1;
    end
  end

  assign accept = bus.in_valid & ready;

  // A load on a draining channel wins, so the channel stays full with the new word.
  always_comb begin
    load = '0;
    if (accept) begin
      load = bus.in_bcast ? {M{1'b1}} : sel_oh;
    end
    full_d = (full_q & ~bus.out_ready) | load;
    data_d = data_q;
    for (int unsigned k = 0; k < M; k++) begin
      if (load[k]) begin
        data_d[k*N +: N] = bus.in_data;
      end
    end
    err_d = accept & ~bus.in_bcast & ~sel_ok;
    cnt_d = cnt_q;
    if (err_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = full_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = cnt_q;
endmodule

// File: tb/tb_nbit_demux_router.sv
// Bench for nbit_demux_router: vector table on M=4, hand sequences on M=3/CNT_W=2,
// and a randomized soak on M=5 against a per-channel queue model.
module tb_nbit_demux_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nbit_demux_router_if #(.N(5), .M(4), .CNT_W(8)) if4 ();
  nbit_demux_router_if #(.N(5), .M(3), .CNT_W(2)) if3 ();
  nbit_demux_router_if #(.N(5), .M(5), .CNT_W(8)) if5 ();

  nbit_demux_router #(.N(5), .M(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  nbit_demux_router #(.N(5), .M(3), .CNT_W(2)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  nbit_demux_router #(.N(5), .M(5), .CNT_W(8)) u_dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic       b;
    logic [1:0] sel;
    logic [4:0] d;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
    logic [19:0] od;
  } row_t;

  row_t rows[10];

  logic [4:0] q[5][$];
  int         drops;
  logic       err_m;
  logic       hold;
  logic       exp_rdy;
  logic [4:0] can;

  initial begin
    rows[0] = '{1'b1, 1'b0, 2'd2, 5'h1A, 4'b1111, 1'b1, 4'b0100, 20'h06800};
    rows[1] = '{1'b0, 1'b0, 2'd2, 5'h00, 4'b1111, 1'b1, 4'b0000, 20'h06800};
    rows[2] = '{1'b1, 1'b0, 2'd1, 5'h03, 4'b1101, 1'b1, 4'b0010, 20'h06860};
    rows[3] = '{1'b1, 1'b0, 2'd1, 5'h04, 4'b1101, 1'b0, 4'b0010, 20'h06860};
    rows[4] = '{1'b1, 1'b0, 2'd1, 5'h04, 4'b1111, 1'b1, 4'b0010, 20'h06880};
    rows[5] = '{1'b0, 1'b0, 2'd1, 5'h00, 4'b1111, 1'b1, 4'b0000, 20'h06880};
    rows[6] = '{1'b1, 1'b0, 2'd3, 5'h0B, 4'b0111, 1'b1, 4'b1000, 20'h5E880};
    rows[7] = '{1'b1, 1'b1, 2'd0, 5'h15, 4'b0111, 1'b0, 4'b1000, 20'h5E880};
    rows[8] = '{1'b1, 1'b1, 2'd0, 5'h15, 4'b1111, 1'b1, 4'b1111, 20'hAD6B5};
    rows[9] = '{1'b0, 1'b0, 2'd0, 5'h00, 4'b1111, 1'b1, 4'b0000, 20'hAD6B5};

    if4.in_data = '0; if4.in_sel = '0; if4.in_bcast = 1'b0; if4.in_valid = 1'b0;
    if4.out_ready = '1;
    if3.in_data = '0; if3.in_sel = '0; if3.in_bcast = 1'b0; if3.in_valid = 1'b0;
    if3.out_ready = '0;
    if5.in_data = '0; if5.in_sel = '0; if5.in_bcast = 1'b0; if5.in_valid = 1'b0;
    if5.out_ready = '0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(if4.in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
    chk("rst_out_data", 32'(if4.out_data), 32'd0);
    chk("rst_err", 32'(if4.err), 32'd0);
    chk("rst_drop_cnt", 32'(if4.drop_cnt), 32'd0);

    // T1-T3 vector table
    for (int i = 0; i < 10; i++) begin
      if4.in_valid = rows[i].v; if4.in_bcast = rows[i].b; if4.in_sel = rows[i].sel;
      if4.in_data = rows[i].d; if4.out_ready = rows[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(if4.in_ready), 32'(rows[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(if4.out_valid), 32'(rows[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(if4.out_data), 32'(rows[i].od));
      chk($sformatf("vec%0d_err", i), 32'(if4.err), 32'd0);
    end
    if4.in_valid = 1'b0; if4.in_bcast = 1'b0;

    // T4 invalid select on M=3, CNT_W=2
    for (int i = 0; i < 5; i++) begin
      if3.in_valid = 1'b1; if3.in_sel = 2'd3; if3.in_data = 5'(i + 1);
      #1;
      chk("drop_in_ready", 32'(if3.in_ready), 32'd1);
      @(posedge clk); #1;
      chk("drop_err", 32'(if3.err), 32'd1);
      chk("drop_out_valid", 32'(if3.out_valid), 32'd0);
      chk("drop_cnt", 32'(if3.drop_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      if (i == 2) begin
        if3.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drop_err_pulse", 32'(if3.err), 32'd0);
      end
    end
    if3.in_bcast = 1'b1; if3.in_sel = 2'd3; if3.in_data = 5'h0C; if3.in_valid = 1'b1;
    #1;
    chk("bcast_badsel_ready", 32'(if3.in_ready), 32'd1);
    @(posedge clk); #1;
    if3.in_valid = 1'b0; if3.in_bcast = 1'b0;
    chk("bcast_badsel_valid", 32'(if3.out_valid), 32'h7);
    chk("bcast_badsel_data", 32'(if3.out_data), 32'h0318C);
    chk("bcast_badsel_err", 32'(if3.err), 32'd0);
    chk("bcast_badsel_cnt", 32'(if3.drop_cnt), 32'd3);

    // T5 async reset with channels 0 and 2 full
    if4.out_ready = 4'b0000; if4.in_valid = 1'b1;
    if4.in_sel = 2'd0; if4.in_data = 5'h07;
    @(posedge clk); #1;
    if4.in_sel = 2'd2; if4.in_data = 5'h09;
    @(posedge clk); #1;
    chk("t5_pre_valid", 32'(if4.out_valid), 32'h5);
    if4.in_sel = 2'd0; if4.in_data = 5'h11;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(if4.out_valid), 32'd0);
    chk("t5_rst_data", 32'(if4.out_data), 32'd0);
    chk("t5_rst_ready", 32'(if4.in_ready), 32'd0);
    chk("t5_rst_drop_cnt", 32'(if3.drop_cnt), 32'd0);
    chk("t5_rst_valid3", 32'(if3.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    if4.out_ready = 4'b1111;
    #1;
    chk("t5_post_ready", 32'(if4.in_ready), 32'd1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    chk("t5_post_valid", 32'(if4.out_valid), 32'h1);
    chk("t5_post_data", 32'(if4.out_data), 32'h11);

    // T6 random soak on M=5
    drops = 0; err_m = 1'b0; hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 5; k++) begin
        chk("soak_out_valid", 32'(if5.out_valid[k]), 32'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          chk("soak_out_data", 32'(if5.out_data[k*5 +: 5]), 32'(q[k][0]));
        end
      end
      chk("soak_err", 32'(if5.err), 32'(err_m));
      chk("soak_drop_cnt", 32'(if5.drop_cnt), 32'(drops));
      if (!hold) begin
        if5.in_valid = ($urandom_range(9) < 7);
        if5.in_bcast = ($urandom_range(7) == 0);
        if5.in_sel   = 3'($urandom_range(7));
        if5.in_data  = 5'($urandom);
      end
      if5.out_ready = 5'($urandom) | 5'($urandom);
      #1;
      for (int k = 0; k < 5; k++) can[k] = (q[k].size() == 0) || if5.out_ready[k];
      if (if5.in_bcast) exp_rdy = &can;
      else if (if5.in_sel < 3'd5) exp_rdy = can[if5.in_sel];
      else exp_rdy = 1'b1;
      chk("soak_in_ready", 32'(if5.in_ready), 32'(exp_rdy));
      hold = if5.in_valid && !exp_rdy;
      for (int k = 0; k < 5; k++) begin
        if (q[k].size() != 0 && if5.out_ready[k]) void'(q[k].pop_front());
      end
      err_m = 1'b0;
      if (if5.in_valid && exp_rdy) begin
        if (if5.in_bcast) begin
          for (int k = 0; k < 5; k++) q[k].push_back(if5.in_data);
        end else if (if5.in_sel < 3'd5) begin
          q[if5.in_sel].push_back(if5.in_data);
        end else begin
          err_m = 1'b1;
          if (drops < 255) drops++;
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
